// File: rtl/stream_rr_frame_arbiter.sv
`default_nettype none
// ============================================================================
// stream_rr_frame_arbiter : round-robin, frame-granular ready/valid arbiter
// Revision: 1.0
// ============================================================================
module stream_rr_frame_arbiter #(
  parameter int unsigned N_INP = 4,
  parameter type         T     = logic,
  parameter int unsigned IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [N_INP-1:0] inp_valid_i,
  output logic [N_INP-1:0] inp_ready_o,
  input  T                 inp_data_i [N_INP],
  input  logic [N_INP-1:0] inp_last_i,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output T                 oup_data_o,
  output logic             oup_last_o,
  output logic [IDX_W-1:0] oup_idx_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [CNT_W-1:0] cand;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_hit;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_en;
  logic             accept;
  logic             frame_end;

  // First valid input at or after rr_ptr, wrapping modulo N_INP.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int k = 0; k < N_INP; k++) begin
      cand = {1'b0, rr_ptr_q} + CNT_W'(k);
      if (cand >= CNT_W'(N_INP)) begin
        cand = cand - CNT_W'(N_INP);
      end
      if (!scan_hit && inp_valid_i[cand[IDX_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_en  = 1'b0;
    gnt_idx = '0;
    if (!(rst_i || clr_i)) begin
      if (state_q == LOCKED) begin
        gnt_en  = 1'b1;
        gnt_idx = lock_idx_q;
      end else if (scan_hit) begin
        gnt_en  = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    inp_ready_o = '0;
    oup_valid_o = 1'b0;
    oup_data_o  = '0;
    oup_last_o  = 1'b0;
    oup_idx_o   = '0;
    if (gnt_en) begin
      inp_ready_o[gnt_idx] = oup_ready_i;
      if (inp_valid_i[gnt_idx]) begin
        oup_valid_o = 1'b1;
        oup_data_o  = inp_data_i[gnt_idx];
        oup_last_o  = inp_last_i[gnt_idx];
        oup_idx_o   = gnt_idx;
      end
    end
  end

  assign accept    = oup_valid_o & oup_ready_i;
  assign frame_end = accept & oup_last_o;

  // Locking on any non-terminal or stalled offer keeps the grant stable.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (clr_i) begin
      state_d    = IDLE;
      rr_ptr_d   = '0;
      lock_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (oup_valid_o && !frame_end) begin
            state_d    = LOCKED;
            lock_idx_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (frame_end) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (frame_end) begin
        rr_ptr_d = (gnt_idx == IDX_W'(N_INP - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(inp_ready_o));
  a_lock_range: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(lock_idx_q) < N_INP);
  a_clr_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
    clr_i |-> (inp_ready_o == '0 && !oup_valid_o));
`endif

endmodule
`default_nettype wire
